// File: rtl/ritc_ring_capture.sv
// Multi-channel circular sample capture with trigger, post-trigger countdown
// and logically addressed readout (offset 0 = oldest surviving sample).
module ritc_ring_capture #(
   parameter int unsigned NCH       = 6,
   parameter int unsigned WIDTH     = 48,
   parameter int unsigned ADDR_BITS = 9,
   parameter int unsigned CHAN_BITS = 3
) (
   input  logic                   sysclk_i,
   input  logic                   rst_n_i,
   input  logic [NCH*WIDTH-1:0]   dat_i,
   input  logic                   sync_i,
   input  logic                   arm_i,
   input  logic                   trig_i,
   input  logic                   clear_i,
   input  logic [ADDR_BITS-1:0]   post_len_i,
   input  logic                   rd_load_i,
   input  logic [ADDR_BITS-1:0]   rd_offset_i,
   input  logic                   rd_i,
   input  logic [CHAN_BITS-1:0]   rd_chan_i,
   output logic [WIDTH-1:0]       rd_dat_o,
   output logic                   rd_valid_o,
   output logic                   armed_o,
   output logic                   done_o,
   output logic                   sync_latch_o,
   output logic [ADDR_BITS:0]     count_o,
   output logic [ADDR_BITS-1:0]   trig_addr_o
);
   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG, S_DONE} state_t;
   state_t state_q, state_d;

   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d, trig_addr_q, trig_addr_d;
   logic [ADDR_BITS:0]   fill_q, fill_d;
   logic                 sync_q, sync_d;
   logic                 rd_valid_q, rd_hit_q;
   logic [CHAN_BITS-1:0] rd_chan_q;
   logic                 wr_en, rd_en, trig_acc, arm_acc;
   logic [ADDR_BITS-1:0] start, rd_addr;
   logic [NCH*WIDTH-1:0] rd_all;

   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (arm_i) state_d = S_ARMED;
            S_ARMED: if (trig_i) state_d = (post_len_i == '0) ? S_DONE : S_TRIG;
            S_TRIG:  if (post_cnt_q == ADDR_BITS'(1)) state_d = S_DONE;
            S_DONE:  if (arm_i) state_d = S_ARMED;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      armed_o = (state_q == S_ARMED) || (state_q == S_TRIG);
      done_o  = (state_q == S_DONE);
   end

   assign wr_en    = !clear_i && ((state_q == S_ARMED) || (state_q == S_TRIG));
   assign trig_acc = !clear_i && (state_q == S_ARMED) && trig_i;
   assign arm_acc  = arm_i && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign rd_en    = rd_i && (state_q == S_DONE);
   // A full buffer has fill low bits of zero, so start collapses onto wr_ptr.
   assign start    = wr_ptr_q - fill_q[ADDR_BITS-1:0];
   assign rd_addr  = rd_load_i ? start + rd_offset_i : rd_ptr_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      post_cnt_d  = post_cnt_q;
      trig_addr_d = trig_addr_q;
      sync_d      = sync_q;
      rd_ptr_d    = rd_ptr_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
         if (fill_q != (ADDR_BITS+1)'(DEPTH)) fill_d = fill_q + (ADDR_BITS+1)'(1);
      end
      if (clear_i || arm_acc) fill_d = '0;
      if (trig_acc) begin
         trig_addr_d = wr_ptr_q;
         sync_d      = sync_i;
         post_cnt_d  = post_len_i;
      end else if (wr_en && (state_q == S_TRIG)) begin
         post_cnt_d = post_cnt_q - ADDR_BITS'(1);
      end
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         rd_ptr_d = wr_ptr_d - fill_d[ADDR_BITS-1:0];
      end else if (rd_en) begin
         rd_ptr_d = rd_addr + ADDR_BITS'(1);
      end else if (rd_load_i && (state_q == S_DONE)) begin
         rd_ptr_d = rd_addr;
      end
   end

   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         post_cnt_q  <= '0;
         trig_addr_q <= '0;
         sync_q      <= 1'b0;
         rd_ptr_q    <= '0;
         rd_valid_q  <= 1'b0;
         rd_hit_q    <= 1'b0;
         rd_chan_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         post_cnt_q  <= post_cnt_d;
         trig_addr_q <= trig_addr_d;
         sync_q      <= sync_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_valid_q  <= rd_i;
         if (rd_i) begin
            rd_hit_q  <= rd_en && (32'(rd_chan_i) < NCH);
            rd_chan_q <= rd_chan_i;
         end
      end
   end

   // Per-channel RAM; read register only loads on an honoured read so data holds.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] word_q;
      always_ff @(posedge sysclk_i) begin
         if (wr_en) mem[wr_ptr_q] <= dat_i[c*WIDTH +: WIDTH];
         if (rd_en) word_q <= mem[rd_addr];
      end
      assign rd_all[c*WIDTH +: WIDTH] = word_q;
   end

   always_comb begin
      rd_dat_o = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (rd_hit_q && (rd_chan_q == CHAN_BITS'(c))) rd_dat_o = rd_all[c*WIDTH +: WIDTH];
      end
   end

   assign rd_valid_o   = rd_valid_q;
   assign sync_latch_o = sync_q;
   assign count_o      = fill_q;
   assign trig_addr_o  = trig_addr_q;
endmodule

// File: tb/tb_ritc_ring_capture.sv
// Scoreboard bench for ritc_ring_capture: a capture-history model predicts
// read data; a negedge monitor checks every rd_valid_o against the queue.
module tb_ritc_ring_capture;
   localparam int NCH = 6, WIDTH = 48, AB = 9, CB = 3, DEPTH = 512;

   logic                 clk = 1'b0, rst_n = 1'b0;
   logic [NCH*WIDTH-1:0] dat_i = '0;
   logic                 sync_i = 1'b0, arm_i = 1'b0, trig_i = 1'b0, clear_i = 1'b0;
   logic [AB-1:0]        post_len_i = '0, rd_offset_i = '0;
   logic                 rd_load_i = 1'b0, rd_i = 1'b0;
   logic [CB-1:0]        rd_chan_i = '0;
   logic [WIDTH-1:0]     rd_dat_o;
   logic                 rd_valid_o, armed_o, done_o, sync_latch_o;
   logic [AB:0]          count_o;
   logic [AB-1:0]        trig_addr_o;

   ritc_ring_capture #(.NCH(NCH), .WIDTH(WIDTH), .ADDR_BITS(AB), .CHAN_BITS(CB)) dut (
      .sysclk_i(clk), .rst_n_i(rst_n), .dat_i(dat_i), .sync_i(sync_i), .arm_i(arm_i),
      .trig_i(trig_i), .clear_i(clear_i), .post_len_i(post_len_i), .rd_load_i(rd_load_i),
      .rd_offset_i(rd_offset_i), .rd_i(rd_i), .rd_chan_i(rd_chan_i), .rd_dat_o(rd_dat_o),
      .rd_valid_o(rd_valid_o), .armed_o(armed_o), .done_o(done_o), .sync_latch_o(sync_latch_o),
      .count_o(count_o), .trig_addr_o(trig_addr_o));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [WIDTH-1:0] d; int due;} exp_t;
   exp_t sbq[$];
   exp_t e;
   logic [NCH*WIDTH-1:0] hist[$];
   int checks = 0, errors = 0;
   int wr_base = 0, lptr = 0;
   logic [WIDTH-1:0] last_exp = '0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rd_valid", {63'd0, rd_valid_o}, 64'd1);
            chk("rd_dat", {16'd0, rd_dat_o}, {16'd0, e.d});
         end else if (rd_valid_o) begin
            chk("rd_valid_spurious", {63'd0, rd_valid_o}, 64'd0);
         end
      end
   end

   function automatic logic [NCH*WIDTH-1:0] mkword(int i, bit ramp);
      logic [NCH*WIDTH-1:0] w;
      for (int c = 0; c < NCH; c++)
         w[c*WIDTH +: WIDTH] = ramp ? (WIDTH'(i) + (WIDTH'(c) << 40)) : WIDTH'({$urandom(), $urandom()});
      return w;
   endfunction

   // Expected word at logical position lp: oldest surviving sample is position 0.
   function automatic logic [WIDTH-1:0] model_rd(int lp, int chan);
      int cnt = (hist.size() < DEPTH) ? hist.size() : DEPTH;
      int idx = hist.size() - cnt + (lp % DEPTH);
      logic [NCH*WIDTH-1:0] w;
      if (chan >= NCH) return '0;
      w = hist[idx];
      return w[chan*WIDTH +: WIDTH];
   endfunction

   task automatic rd(bit load, int off, int chan, bit in_done);
      logic [WIDTH-1:0] x;
      @(negedge clk);
      if (load && in_done) lptr = off;
      x = in_done ? model_rd(lptr, chan) : '0;
      if (in_done) lptr++;
      rd_load_i = load; rd_offset_i = AB'(off); rd_chan_i = CB'(chan); rd_i = 1'b1;
      sbq.push_back('{d: x, due: cyc + 1});
      last_exp = x;
   endtask

   task automatic rd_idle();
      @(negedge clk);
      rd_i = 1'b0; rd_load_i = 1'b0;
   endtask

   task automatic capture(int pre, int post, bit sync, bit ramp);
      int n = pre + post;
      hist.delete();
      @(negedge clk); arm_i = 1'b1;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i == n) begin
            chk("done_before_last", {63'd0, done_o}, 64'd0);
            chk("armed_before_last", {63'd0, armed_o}, 64'd1);
         end
         arm_i      = (i > 0) && (i == pre / 2) && (i != pre);
         dat_i      = mkword(i, ramp);
         hist.push_back(dat_i);
         trig_i     = (i == pre);
         sync_i     = (i == pre) ? sync : ~sync;
         post_len_i = (i == pre) ? AB'(post) : AB'($urandom);
      end
      @(negedge clk);
      trig_i = 1'b0; arm_i = 1'b0;
      chk("done", {63'd0, done_o}, 64'd1);
      chk("armed_in_done", {63'd0, armed_o}, 64'd0);
      chk("count", 64'(count_o), 64'((hist.size() < DEPTH) ? hist.size() : DEPTH));
      chk("trig_addr", 64'(trig_addr_o), 64'((wr_base + pre) % DEPTH));
      chk("sync_latch", {63'd0, sync_latch_o}, {63'd0, sync});
      wr_base += hist.size();
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_done"}, {63'd0, done_o}, 64'd0);
      chk({tag, "_armed"}, {63'd0, armed_o}, 64'd0);
      chk({tag, "_count"}, 64'(count_o), 64'd0);
      chk({tag, "_trig_addr"}, 64'(trig_addr_o), 64'd0);
      chk({tag, "_sync"}, {63'd0, sync_latch_o}, 64'd0);
      chk({tag, "_rd_valid"}, {63'd0, rd_valid_o}, 64'd0);
      chk({tag, "_rd_dat"}, {16'd0, rd_dat_o}, 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("reset");

      // Idle: reads return zero, trigger ignored
      rd(0, 0, 0, 0); rd_idle();
      @(negedge clk); trig_i = 1'b1;
      @(negedge clk); trig_i = 1'b0;
      chk("idle_trig_armed", {63'd0, armed_o}, 64'd0);
      chk("idle_trig_done", {63'd0, done_o}, 64'd0);

      // Ramp capture, 600 pre, 100 post
      capture(600, 100, 1'b1, 1'b1);
      rd(1, 0, 0, 1);
      rd(1, 411, 0, 1);
      rd(1, 411, 3, 1);
      for (int k = 0; k < 20; k++) rd(1, $urandom_range(0, DEPTH - 1), $urandom_range(0, NCH - 1), 1);
      rd_idle();
      repeat (3) @(negedge clk);
      chk("rd_dat_hold", {16'd0, rd_dat_o}, {16'd0, last_exp});

      // Short capture, sequential readout with auto-increment
      capture(50, 10, 1'b0, 1'b0);
      rd(1, 0, $urandom_range(0, NCH - 1), 1);
      for (int k = 1; k < 61; k++) rd(0, 0, $urandom_range(0, NCH - 1), 1);
      rd_idle();

      // Zero post length: trigger word is the newest
      capture(15, 0, 1'b1, 1'b0);
      for (int c = 0; c < NCH; c++) rd(1, 15, c, 1);
      rd_idle();

      // Maximum post length, full buffer, read wraps after 512
      capture(20, 511, 1'b0, 1'b0);
      rd(1, 0, 0, 1);
      for (int k = 1; k < 513; k++) rd(0, 0, $urandom_range(0, NCH - 1), 1);
      rd(1, 0, 0, 1);
      rd_idle();

      // Clear during TRIGGERED
      @(negedge clk); arm_i = 1'b1;
      for (int i = 0; i <= 40; i++) begin
         @(negedge clk);
         arm_i = 1'b0; dat_i = mkword(i, 1'b0);
         trig_i = (i == 30); post_len_i = AB'(50);
      end
      @(negedge clk);
      trig_i = 1'b0; clear_i = 1'b1;
      chk("clr_trig_addr", 64'(trig_addr_o), 64'((wr_base + 30) % DEPTH));
      chk("clr_pre_armed", {63'd0, armed_o}, 64'd1);
      @(negedge clk); clear_i = 1'b0;
      chk("clr_armed", {63'd0, armed_o}, 64'd0);
      chk("clr_done", {63'd0, done_o}, 64'd0);
      chk("clr_count", 64'(count_o), 64'd0);
      rd(1, 3, 1, 0); rd_idle();
      @(negedge clk); trig_i = 1'b1;
      @(negedge clk); trig_i = 1'b0;
      repeat (60) @(negedge clk);
      chk("clr_trig_ignored_armed", {63'd0, armed_o}, 64'd0);
      chk("clr_stays_not_done", {63'd0, done_o}, 64'd0);
      @(negedge clk); arm_i = 1'b1; clear_i = 1'b1;
      @(negedge clk); arm_i = 1'b0; clear_i = 1'b0;
      chk("arm_clear_armed", {63'd0, armed_o}, 64'd0);

      // Reset, then capture and async reset mid-readout
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; wr_base = 0;
      @(negedge clk);
      chk_all_zero("rst2");
      capture(5, 7, 1'b1, 1'b0);
      rd(1, 0, 7, 1);
      rd(1, 3, 2, 1);
      rd_idle();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("sb_drain", 64'(sbq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
